multi_signal_debouncer: RTL and testbench
=========================================

MULTI_SIGNAL_DEBOUNCER -- requirements
Module: multi_signal_debouncer

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent input channels, at least 1.
REQ-002 Parameter DEBOUNCE_COUNT, default 65_536: consecutive stable cycles required to commit a level change, at least 2.
REQ-003 Parameter SYNC_STAGES, default 2: synchroniser depth per channel, at least 2.
REQ-004 Parameter IN_ACTIVE_LOW, default all ones, NUM_CH bits: per-channel input polarity; bit i = 1 means channel i is active-low.
REQ-005 Parameter HOLD_COUNT, default 1_000_000: cycles of committed-active level before a hold event, at least 1.
REQ-006 sys_clk  input  1  sole clock; all logic is on its rising edge.
REQ-007 sys_rst  input  1  reset, synchronous and active-high.
REQ-008 in_sig  input  NUM_CH  raw inputs; may be asynchronous to sys_clk.
REQ-009 level  output  NUM_CH  debounced level per channel, active-high regardless of input polarity.
REQ-010 rise_pulse  output  NUM_CH  one-cycle pulse when a channel's level commits to 1.
REQ-011 fall_pulse  output  NUM_CH  one-cycle pulse when a channel's level commits to 0.
REQ-012 any_event  output  1  OR of all rise_pulse and fall_pulse bits, in the same cycle.
REQ-013 hold_pulse  output  NUM_CH  one-cycle long-press pulse (see Configuration).

Function
REQ-014 Each channel SHALL pass in_sig[i] through SYNC_STAGES flops, then normalise polarity to an internal active-high "act".
REQ-015 Each channel SHALL keep a counter of width clog2(DEBOUNCE_COUNT).
- If act equals level, the counter clears to 0.
- If act differs from level and the counter is below DEBOUNCE_COUNT-1, the counter increments.
- If act differs from level and the counter equals DEBOUNCE_COUNT-1, level takes act, the counter clears, and the matching rise or fall pulse fires for exactly one cycle.
REQ-016 Latency: level SHALL update on clock edge SYNC_STAGES+DEBOUNCE_COUNT, counting the first edge that samples a new, stable input value as edge 1.
REQ-017 Any reversion of act during counting SHALL clear the counter with no output change; counting restarts from 0 on the next difference.
REQ-018 Channels SHALL be fully independent; simultaneous commits on several channels each produce their own pulse in the same cycle.
REQ-019 rise_pulse[i] and fall_pulse[i] SHALL never be high together, and there SHALL be no pulse without a level change.

Reset
REQ-020 While sys_rst is high, all synchroniser flops SHALL load the inactive input value for their channel's polarity.
REQ-021 While sys_rst is high, level, all counters, rise_pulse, fall_pulse, hold_pulse and any_event SHALL be 0.
REQ-022 Reset asserted mid-count or mid-hold SHALL abort silently with no pulse.
REQ-023 An input already active when reset releases SHALL need the full REQ-016 latency before level asserts.

Configuration
REQ-024 Macro MULTI_SIGNAL_DEBOUNCER_HOLD_EN defined:
- Each channel has a saturating hold counter of width clog2(HOLD_COUNT+1), cleared whenever level is 0.
- hold_pulse[i] fires once, for one cycle, when level[i] has been 1 for HOLD_COUNT consecutive cycles after the rise commit.
- There is no repeat; hold re-arms only after a fall commit.
REQ-025 Macro not defined: no hold logic SHALL be synthesised, and hold_pulse SHALL be tied to 0; the port list is unchanged.

Structure
REQ-026 Shared package debounce_pkg SHALL hold the counter-width constants/functions and the default DEBOUNCE_COUNT and HOLD_COUNT values.
REQ-027 Per-channel logic SHALL live in sub-module debounce_channel (synchroniser, counter, hold logic), instantiated NUM_CH times by a generate loop.
REQ-028 The top level SHALL contain only the instances and the any_event OR-reduction.

Verification (NUM_CH=2, DEBOUNCE_COUNT=8, SYNC_STAGES=2, HOLD_COUNT=20, IN_ACTIVE_LOW=2'b01)
REQ-029 Clean press:
- Stimulus: in_sig[0] goes 1->0 and is held.
- Response: rise_pulse[0] high for one cycle at edge 10, level[0]=1 from then, any_event=1 in the same cycle.
REQ-030 Glitch:
- Stimulus: in_sig[1] goes 0->1 for 5 cycles, then returns to 0.
- Response: level[1], rise_pulse[1] and fall_pulse[1] stay 0 throughout.
REQ-031 Bounce:
- Stimulus: in_sig[1] goes high for 6 cycles, low for 1, then high and held.
- Response: rise_pulse[1] at edge 10 counted from the final high edge, not earlier.
REQ-032 Simultaneous release:
- Stimulus: both channels have level=1, then both inputs go inactive on the same edge.
- Response: fall_pulse=2'b11 in one cycle, a single any_event cycle, level=2'b00.
REQ-033 Reset mid-count:
- Stimulus: sys_rst pulsed after 5 stable cycles with the input still active.
- Response: no pulse; after reset release, rise_pulse arrives 10 edges later.
REQ-034 Hold:
- Stimulus: channel 0 held active, with MULTI_SIGNAL_DEBOUNCER_HOLD_EN defined.
- Response: hold_pulse[0] fires once, 20 cycles after the rise commit.
- Without the macro, hold_pulse stays 0.

Source files
------------

// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
//
// Purpose:
//    Shared constants and helpers for the multi-signal debouncer slice.
//    It holds the default debounce and hold lengths and the width helpers
//    that size each channel's counters. It also defines the enum that
//    classifies a per-cycle commit decision.
//
// Contents:
//    DEFAULT_DEBOUNCE_COUNT  default consecutive stable cycles per commit
//    DEFAULT_HOLD_COUNT      default committed-active cycles before a hold
//    DEFAULT_SYNC_STAGES     default synchroniser depth
//    counterWidth()          width of a counter that runs 0 .. n-1
//    holdWidth()             width of a saturating counter that runs 0 .. n
//    commit_e                per-cycle level commit decision
// -----------------------------------------------------------------------------
package debounce_pkg;

   localparam int DEFAULT_DEBOUNCE_COUNT = 65_536;
   localparam int DEFAULT_HOLD_COUNT     = 1_000_000;
   localparam int DEFAULT_SYNC_STAGES    = 2;

   // A counter that only ever needs to reach n-1 fits in clog2(n) bits.
   // The result is never allowed to drop below one bit, so tiny counts
   // still produce a legal vector.
   function automatic int counterWidth(input int n);
      int w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

   // The hold counter saturates at n itself, so it needs clog2(n+1) bits.
   function automatic int holdWidth(input int n);
      int w;
      w = $clog2(n + 1);
      return (w < 1) ? 1 : w;
   endfunction

   typedef enum logic [1:0] {
      COMMIT_NONE = 2'b00,
      COMMIT_RISE = 2'b01,
      COMMIT_FALL = 2'b10
   } commit_e;

endpackage : debounce_pkg

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
//
// Purpose:
//    Debounces one raw input. The raw input passes through a synchroniser
//    and has its polarity normalised to active-high. The channel then waits
//    for DEBOUNCE_COUNT consecutive cycles of disagreement with the
//    committed level before it flips that level. Each commit raises a
//    one-cycle rise or fall pulse. An optional long-press detector raises
//    one hold pulse after the level has been high for HOLD_COUNT cycles.
//
// Configuration:
//    MULTI_SIGNAL_DEBOUNCER_HOLD_EN  when defined, builds the hold counter.
//                                    Otherwise hold_o is tied low.
//
// Ports:
//    clk_i    in   1  clock, rising edge
//    rst_i    in   1  synchronous active-high reset
//    raw_i    in   1  raw input, may be asynchronous to clk_i
//    level_o  out  1  committed level, active-high
//    rise_o   out  1  one-cycle pulse on a commit to 1
//    fall_o   out  1  one-cycle pulse on a commit to 0
//    hold_o   out  1  one-cycle long-press pulse
// -----------------------------------------------------------------------------
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int   DEBOUNCE_COUNT = DEFAULT_DEBOUNCE_COUNT,
   parameter int   SYNC_STAGES    = DEFAULT_SYNC_STAGES,
   parameter logic ACTIVE_LOW     = 1'b1,
   parameter int   HOLD_COUNT     = DEFAULT_HOLD_COUNT
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic raw_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o,
   output logic hold_o
);

   localparam int            CW       = counterWidth(DEBOUNCE_COUNT);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_COUNT - 1);

   // The raw level that counts as "not pressed" equals the polarity bit.
   // An active-low input idles high, and an active-high input idles low.
   localparam logic INACTIVE_RAW = ACTIVE_LOW;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   act;
   logic [CW-1:0]          debounceCnt_q, debounceCnt_d;
   logic                   level_q, level_d;
   logic                   rise_q, fall_q;
   commit_e                commit;

   // Synchroniser chain. Reset preloads the idle value so that an input
   // already held active at reset release is seen as a fresh change. That
   // change then has to travel the full synchroniser and debounce latency.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= {SYNC_STAGES{INACTIVE_RAW}};
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
      end
   end

   assign act = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;

   // Debounce decision. Agreement with the committed level, or any reversion
   // during counting, clears the counter. Disagreement advances the counter.
   // On the cycle that would reach DEBOUNCE_COUNT, the level flips and the
   // counter restarts. The counter therefore never holds DEBOUNCE_COUNT.
   always_comb begin
      commit        = COMMIT_NONE;
      level_d       = level_q;
      debounceCnt_d = '0;
      if (act != level_q) begin
         if (debounceCnt_q == CNT_LAST) begin
            level_d = act;
            commit  = act ? COMMIT_RISE : COMMIT_FALL;
         end else begin
            debounceCnt_d = debounceCnt_q + 1'b1;
         end
      end
   end

   // Level, counter and edge pulses. The pulses are registered together
   // with the level, so each pulse coincides with the first cycle of the
   // new level.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         level_q       <= 1'b0;
         debounceCnt_q <= '0;
         rise_q        <= 1'b0;
         fall_q        <= 1'b0;
      end else begin
         level_q       <= level_d;
         debounceCnt_q <= debounceCnt_d;
         rise_q        <= (commit == COMMIT_RISE);
         fall_q        <= (commit == COMMIT_FALL);
      end
   end

   assign level_o = level_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;

`ifdef MULTI_SIGNAL_DEBOUNCER_HOLD_EN
   localparam int            HW        = holdWidth(HOLD_COUNT);
   localparam logic [HW-1:0] HOLD_SAT  = HW'(HOLD_COUNT);
   localparam logic [HW-1:0] HOLD_FIRE = HW'(HOLD_COUNT - 1);

   logic [HW-1:0] holdCnt_q, holdCnt_d;
   logic          holdPulse_q, holdPulse_d;

   // Long-press detection. The counter counts committed-high cycles and
   // saturates at HOLD_COUNT, so the fire value is only crossed once per
   // press. A low level clears the counter, which re-arms the detector only
   // after a fall commit.
   always_comb begin
      holdCnt_d   = '0;
      holdPulse_d = 1'b0;
      if (level_q) begin
         holdPulse_d = (holdCnt_q == HOLD_FIRE);
         holdCnt_d   = (holdCnt_q == HOLD_SAT) ? holdCnt_q : holdCnt_q + 1'b1;
      end
   end

   // Hold counter and hold pulse registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         holdCnt_q   <= '0;
         holdPulse_q <= 1'b0;
      end else begin
         holdCnt_q   <= holdCnt_d;
         holdPulse_q <= holdPulse_d;
      end
   end

   assign hold_o = holdPulse_q;
`else
   // Without long-press support there is no hold logic at all. The port
   // remains for a stable interface.
   localparam int unusedHoldCount = HOLD_COUNT;
   assign hold_o = 1'b0;
`endif

endmodule : debounce_channel

// File: rtl/multi_signal_debouncer.sv
// -----------------------------------------------------------------------------
// multi_signal_debouncer
//
// Purpose:
//    NUM_CH independent debounced inputs, each with its own polarity. Every
//    channel is a debounce_channel instance. The top level adds only the
//    combined event flag.
//
// Configuration:
//    MULTI_SIGNAL_DEBOUNCER_HOLD_EN  when defined, enables per-channel
//                                    long-press (hold) pulses. Otherwise
//                                    hold_pulse is tied to 0.
//
// Ports:
//    sys_clk     in   1       sole clock, rising edge
//    sys_rst     in   1       synchronous active-high reset
//    in_sig      in   NUM_CH  raw inputs, may be asynchronous
//    level       out  NUM_CH  debounced levels, active-high
//    rise_pulse  out  NUM_CH  one-cycle pulse on commit to 1
//    fall_pulse  out  NUM_CH  one-cycle pulse on commit to 0
//    any_event   out  1       OR of all rise and fall pulses
//    hold_pulse  out  NUM_CH  one-cycle long-press pulse
// -----------------------------------------------------------------------------
module multi_signal_debouncer
   import debounce_pkg::*;
#(
   parameter int                NUM_CH         = 4,
   parameter int                DEBOUNCE_COUNT = DEFAULT_DEBOUNCE_COUNT,
   parameter int                SYNC_STAGES    = DEFAULT_SYNC_STAGES,
   parameter logic [NUM_CH-1:0] IN_ACTIVE_LOW  = '1,
   parameter int                HOLD_COUNT     = DEFAULT_HOLD_COUNT
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic [NUM_CH-1:0] in_sig,
   output logic [NUM_CH-1:0] level,
   output logic [NUM_CH-1:0] rise_pulse,
   output logic [NUM_CH-1:0] fall_pulse,
   output logic              any_event,
   output logic [NUM_CH-1:0] hold_pulse
);

   // One fully independent debounce channel per input bit.
   for (genvar i = 0; i < NUM_CH; i++) begin : gChannel
      debounce_channel #(
         .DEBOUNCE_COUNT (DEBOUNCE_COUNT),
         .SYNC_STAGES    (SYNC_STAGES),
         .ACTIVE_LOW     (IN_ACTIVE_LOW[i]),
         .HOLD_COUNT     (HOLD_COUNT)
      ) u_channel (
         .clk_i   (sys_clk),
         .rst_i   (sys_rst),
         .raw_i   (in_sig[i]),
         .level_o (level[i]),
         .rise_o  (rise_pulse[i]),
         .fall_o  (fall_pulse[i]),
         .hold_o  (hold_pulse[i])
      );
   end

   // The pulses are already registered, so this flag lines up with them.
   assign any_event = |{rise_pulse, fall_pulse};

endmodule : multi_signal_debouncer

// File: tb/tb_multi_signal_debouncer.sv
// -----------------------------------------------------------------------------
// tb_multi_signal_debouncer
//
// Self-checking bench for multi_signal_debouncer. The bench uses two
// channels, DEBOUNCE_COUNT=8, SYNC_STAGES=2, HOLD_COUNT=20 and
// IN_ACTIVE_LOW=2'b01.
//
// The reference model works on per-edge history rather than counters. The
// counter sees each input sample SYNC edges after it was taken. A level
// commits once the last DEBOUNCE_COUNT seen samples all disagree with the
// level, and all of them fall after the previous commit or reset. A hold
// fires exactly HOLD_COUNT edges after a rise, if the level is still high.
// -----------------------------------------------------------------------------
module tb_multi_signal_debouncer;

   localparam int         NUM_CH = 2;
   localparam int         DC     = 8;
   localparam int         SYNC   = 2;
   localparam int         HOLD   = 20;
   localparam logic [1:0] IAL    = 2'b01;
   localparam logic [1:0] IDLE   = 2'b01;
   localparam logic [1:0] BOTH   = 2'b10;
   localparam int         MAXE   = 16384;

   logic       sys_clk = 1'b0;
   logic       sys_rst;
   logic [1:0] in_sig;
   logic [1:0] level, rise_pulse, fall_pulse, hold_pulse;
   logic       any_event;

   int vectors     = 0;
   int miscompares = 0;
   int edgeNum     = 0;

   // Reference model state.
   bit         mPipe [NUM_CH][SYNC];
   bit         mHist [NUM_CH][MAXE];
   int         mLastCommit [NUM_CH];
   int         mLastRise   [NUM_CH];
   logic [1:0] mLevel = '0, mRise = '0, mFall = '0, mHold = '0;
   logic       mAny   = 1'b0;

   multi_signal_debouncer #(
      .NUM_CH         (NUM_CH),
      .DEBOUNCE_COUNT (DC),
      .SYNC_STAGES    (SYNC),
      .IN_ACTIVE_LOW  (IAL),
      .HOLD_COUNT     (HOLD)
   ) dut (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .in_sig     (in_sig),
      .level      (level),
      .rise_pulse (rise_pulse),
      .fall_pulse (fall_pulse),
      .any_event  (any_event),
      .hold_pulse (hold_pulse)
   );

   // Free-running clock with a 10-unit period.
   always #5 sys_clk = ~sys_clk;

   function automatic logic [8:0] mVec();
      return {mLevel, mRise, mFall, mHold, mAny};
   endfunction

   function automatic logic [8:0] dutVec();
      return {level, rise_pulse, fall_pulse, hold_pulse, any_event};
   endfunction

   // Advance the model by one rising edge with the given inputs.
   task automatic modelEdge(input logic rst, input logic [1:0] raw);
      bit used, allDiff, levelBefore;
      edgeNum++;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         mRise[ch] = 1'b0;
         mFall[ch] = 1'b0;
         mHold[ch] = 1'b0;
         if (rst) begin
            for (int s = 0; s < SYNC; s++) mPipe[ch][s] = 1'b0;
            mLevel[ch]      = 1'b0;
            mLastCommit[ch] = edgeNum;
            mLastRise[ch]   = -100000;
         end else begin
            levelBefore = mLevel[ch];
            used = mPipe[ch][SYNC-1];
            for (int s = SYNC - 1; s > 0; s--) mPipe[ch][s] = mPipe[ch][s-1];
            mPipe[ch][0] = raw[ch] ^ IAL[ch];
            mHist[ch][edgeNum] = used;
            if (edgeNum - mLastCommit[ch] >= DC) begin
               allDiff = 1'b1;
               for (int k = 0; k < DC; k++)
                  if (mHist[ch][edgeNum-k] == levelBefore) allDiff = 1'b0;
               if (allDiff) begin
                  mLevel[ch]      = ~levelBefore;
                  mRise[ch]       = ~levelBefore;
                  mFall[ch]       = levelBefore;
                  mLastCommit[ch] = edgeNum;
                  if (!levelBefore) mLastRise[ch] = edgeNum;
               end
            end
`ifdef MULTI_SIGNAL_DEBOUNCER_HOLD_EN
            if (levelBefore && (edgeNum - mLastRise[ch] == HOLD)) mHold[ch] = 1'b1;
`endif
         end
      end
      mAny = |{mRise, mFall};
   endtask

   // Drive one cycle of stimulus, clock it and the model, then settle.
   task automatic applyStimulus(input logic rst, input logic [1:0] raw);
      sys_rst = rst;
      in_sig  = raw;
      @(posedge sys_clk);
      modelEdge(rst, raw);
      #1;
   endtask

   task automatic doReset();
      applyStimulus(1'b1, IDLE);
      applyStimulus(1'b1, IDLE);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, IDLE);
   endtask

   task automatic test_reset();
      for (int k = 0; k < 12; k++) begin
         applyStimulus(1'b1, BOTH);
         vectors++;
         if (dutVec() !== 9'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs k=%0d got %b want %b", k, dutVec(), 9'b0);
         end
      end
      for (int k = 1; k <= 12; k++) begin
         applyStimulus(1'b0, IDLE);
         vectors++;
         if (dutVec() !== mVec()) begin
            miscompares++;
            $display("[TB] FAIL reset_release k=%0d got %b want %b", k, dutVec(), mVec());
         end
      end
   endtask

   task automatic test_clean_press();
      doReset();
      for (int k = 1; k <= 14; k++) begin
         applyStimulus(1'b0, 2'b00);
         vectors++;
         if (dutVec() !== mVec()) begin
            miscompares++;
            $display("[TB] FAIL clean_press_model k=%0d got %b want %b", k, dutVec(), mVec());
         end
         vectors++;
         if ({level[0], rise_pulse[0], any_event} !== {k >= 10, k == 10, k == 10}) begin
            miscompares++;
            $display("[TB] FAIL clean_press_edge10 k=%0d got %b want %b", k,
                     {level[0], rise_pulse[0], any_event}, {k >= 10, k == 10, k == 10});
         end
      end
   endtask

   task automatic test_glitch();
      doReset();
      for (int k = 1; k <= 25; k++) begin
         applyStimulus(1'b0, (k <= 5) ? 2'b11 : IDLE);
         vectors++;
         if ({level[1], rise_pulse[1], fall_pulse[1]} !== 3'b000 || dutVec() !== mVec()) begin
            miscompares++;
            $display("[TB] FAIL glitch k=%0d got %b want %b", k, dutVec(), mVec());
         end
      end
   endtask

   task automatic test_bounce();
      doReset();
      for (int k = 1; k <= 7; k++) begin
         applyStimulus(1'b0, (k <= 6) ? 2'b11 : IDLE);
         vectors++;
         if (rise_pulse[1] !== 1'b0 || dutVec() !== mVec()) begin
            miscompares++;
            $display("[TB] FAIL bounce_early k=%0d got %b want %b", k, dutVec(), mVec());
         end
      end
      for (int k = 1; k <= 14; k++) begin
         applyStimulus(1'b0, 2'b11);
         vectors++;
         if ({level[1], rise_pulse[1]} !== {k >= 10, k == 10} || dutVec() !== mVec()) begin
            miscompares++;
            $display("[TB] FAIL bounce_final k=%0d got %b want %b", k, dutVec(), mVec());
         end
      end
   endtask

   task automatic test_simultaneous_release();
      int anyCount;
      doReset();
      for (int k = 1; k <= 12; k++) applyStimulus(1'b0, BOTH);
      vectors++;
      if (level !== 2'b11) begin
         miscompares++;
         $display("[TB] FAIL simul_pressed got %b want %b", level, 2'b11);
      end
      anyCount = 0;
      for (int k = 1; k <= 14; k++) begin
         applyStimulus(1'b0, IDLE);
         anyCount += int'(any_event);
         vectors++;
         if (fall_pulse !== ((k == 10) ? 2'b11 : 2'b00) ||
             level !== ((k >= 10) ? 2'b00 : 2'b11) || rise_pulse !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL simul_release k=%0d got %b want %b", k, dutVec(), mVec());
         end
      end
      vectors++;
      if (anyCount != 1) begin
         miscompares++;
         $display("[TB] FAIL simul_any_count got %0d want 1", anyCount);
      end
   endtask

   task automatic test_reset_mid_count();
      doReset();
      for (int k = 1; k <= 5; k++) applyStimulus(1'b0, 2'b00);
      applyStimulus(1'b1, 2'b00);
      vectors++;
      if (dutVec() !== 9'b0) begin
         miscompares++;
         $display("[TB] FAIL mid_count_reset got %b want %b", dutVec(), 9'b0);
      end
      for (int k = 1; k <= 14; k++) begin
         applyStimulus(1'b0, 2'b00);
         vectors++;
         if ({level[0], rise_pulse[0]} !== {k >= 10, k == 10} || dutVec() !== mVec()) begin
            miscompares++;
            $display("[TB] FAIL mid_count_after k=%0d got %b want %b", k, dutVec(), mVec());
         end
      end
   endtask

   task automatic test_hold();
      logic expHold;
      int   holdCount;
      doReset();
      holdCount = 0;
      for (int k = 1; k <= 45; k++) begin
         applyStimulus(1'b0, 2'b00);
`ifdef MULTI_SIGNAL_DEBOUNCER_HOLD_EN
         expHold = (k == 30);
`else
         expHold = 1'b0;
`endif
         holdCount += int'(hold_pulse[0]);
         vectors++;
         if ({hold_pulse[1], hold_pulse[0]} !== {1'b0, expHold} || dutVec() !== mVec()) begin
            miscompares++;
            $display("[TB] FAIL hold k=%0d got %b want %b", k, dutVec(), mVec());
         end
      end
      vectors++;
`ifdef MULTI_SIGNAL_DEBOUNCER_HOLD_EN
      if (holdCount != 1) begin
`else
      if (holdCount != 0) begin
`endif
         miscompares++;
         $display("[TB] FAIL hold_count got %0d", holdCount);
      end
   endtask

   task automatic test_random();
      int         runLeft [NUM_CH];
      int         rstLeft;
      logic [1:0] raw;
      logic       rst;
      doReset();
      raw     = IDLE;
      rstLeft = 0;
      for (int ch = 0; ch < NUM_CH; ch++) runLeft[ch] = 5;
      for (int n = 0; n < 2500; n++) begin
         if ($urandom_range(0, 299) == 0) rstLeft = $urandom_range(1, 3);
         rst = (rstLeft > 0);
         if (rstLeft > 0) rstLeft--;
         for (int ch = 0; ch < NUM_CH; ch++) begin
            if (runLeft[ch] == 0) begin
               raw[ch]     = ~raw[ch];
               runLeft[ch] = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 7)
                                                          : $urandom_range(8, 30);
            end
            runLeft[ch]--;
         end
         applyStimulus(rst, raw);
         vectors++;
         if (dutVec() !== mVec()) begin
            miscompares++;
            $display("[TB] FAIL random n=%0d got %b want %b", n, dutVec(), mVec());
         end
      end
   endtask

   initial begin
      sys_rst = 1'b1;
      in_sig  = IDLE;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         mLastCommit[ch] = 0;
         mLastRise[ch]   = -100000;
      end
      test_reset();
      test_clean_press();
      test_glitch();
      test_bounce();
      test_simultaneous_release();
      test_reset_mid_count();
      test_hold();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_multi_signal_debouncer
